decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   MIPS ID stage. Consumes the IF/ID pair (PC+4, instruction) from fetch and reads the 32x32 register file.
//   Decodes control and sign-extends the immediate. Resolves BEQ early and detects load-use hazards.
//   Registers everything into the ID/EX pipeline register for execute. Feeds branch target/select back to fetch.
// PARAMETERS
//   REG_COUNT   32   register file depth (index width fixed at 5)
//   DATA_W      32   datapath width
// PORTS
//   clk               in   1   rising-edge clock
//   rst               in   1   synchronous active-high reset
//   if_id_pc_plus4    in   32  PC+4 from IF/ID register
//   if_id_instr       in   32  instruction from IF/ID register
//   wb_reg_write      in   1   writeback enable
//   wb_write_reg      in   5   writeback destination index
//   wb_write_data     in   32  writeback data
//   branch_address    out  32  if_id_pc_plus4 + (sext(imm)<<2), combinational
//   branch_taken      out  1   drives fetch MuxBranchControl, combinational
//   stall             out  1   load-use hold: fetch keeps PC and IF/ID
//   flush_if_id       out  1   = branch_taken; fetch replaces IF/ID with NOP
//   id_ex_pc_plus4    out  32  registered PC+4
//   id_ex_rd1/rd2     out  32  registered rs/rt read data
//   id_ex_imm         out  32  registered sign-extended imm[15:0]
//   id_ex_rs/rt/rd    out  5   registered instr[25:21]/[20:16]/[15:11]
//   id_ex_ctrl        out  9   {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op[1:0]}
// BEHAVIOUR
//   Reset: all id_ex_* outputs = 0; all 32 registers = 0; stall and branch_taken low one cycle later.
//   Register file:
//     - Written on posedge clk when wb_reg_write && wb_write_reg != 0. Reg 0 always reads 0 and is never written.
//     - Internal bypass: if wb_reg_write && wb_write_reg == rs (or rt) != 0, the read returns wb_write_data same cycle.
//   Decode (opcode instr[31:26]; any other opcode -> ctrl = 0, a NOP):
//     - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10
//     - 0x23 LW:     alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00
//     - 0x2B SW:     alu_src=1, mem_write=1, alu_op=00
//     - 0x04 BEQ:    branch=1, alu_op=01
//     - 0x08 ADDI:   alu_src=1, reg_write=1, alu_op=00
//   Load-use stall (combinational):
//     - Condition: stall = id_ex_ctrl.mem_read && id_ex_rt != 0 && (id_ex_rt == rs || (id_ex_rt == rt && op in {R, SW, BEQ})).
//     - While stall: on next edge id_ex_ctrl <= 0 (bubble); data fields still load; branch_taken forced 0.
//     - Stall lasts exactly one cycle for a single LW; IF/ID contents are unchanged across it.
//   Branch:
//     - branch_taken = BEQ && rd1 == rd2 (after bypass) && !stall && !rst.
//     - Address arithmetic is 32-bit, wraps modulo 2^32; negative offsets are sign-extended.
//   ID/EX latency: 1 cycle; it updates every non-reset edge with no enable.
//   Simultaneous events:
//     - Reset dominates stall, branch, and WB write.
//     - WB write to a reg read by a stalled instruction is visible on the retry cycle.
// TESTING
//   1. rst=1 for 2 clk -> all id_ex_* = 0, stall=0, branch_taken=0; read of any reg = 0.
//   2. WB write reg5=0xDEADBEEF same cycle as instr add $3,$5,$0 (0x00A01820) -> next edge id_ex_rd1=0xDEADBEEF, ctrl reg_write=1, reg_dst=1.
//   3. WB write reg0=0x1234 then read $0 -> rd=0; no register modified.
//   4. lw $2,0($1) then add $4,$2,$2 -> stall=1 one cycle, id_ex_ctrl=0 bubble, add issues next cycle.
//   5. $1=$2=7, beq $1,$2,-1 at pc_plus4=0x40 -> branch_taken=1, branch_address=0x3C.
//      Same with $2=8 -> branch_taken=0.
//   6. Unknown opcode 0x3F -> id_ex_ctrl=0; rst asserted during stall -> next edge all outputs 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - Decode stage bus bundle: IF/ID in, writeback in, branch/hazard and ID/EX out
//
// Signals
//   if_id_pc_plus4, if_id_instr            : IF/ID pipeline register contents
//   wb_reg_write, wb_write_reg, wb_write_data : register file writeback port
//   branch_address, branch_taken           : early branch resolution back to fetch
//   stall, flush_if_id                     : fetch hold / IF/ID squash
//   id_ex_*                                : ID/EX pipeline register contents
// Modports
//   master : the pipeline around the stage (drives IF/ID and writeback)
//   slave  : the decode stage itself
interface decode_stage_if;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [31:0] branch_address;
    logic        branch_taken;
    logic        stall;
    logic        flush_if_id;
    logic [31:0] id_ex_pc_plus4;
    logic [31:0] id_ex_rd1;
    logic [31:0] id_ex_rd2;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [8:0]  id_ex_ctrl;

    modport master (
        output if_id_pc_plus4, if_id_instr, wb_reg_write, wb_write_reg, wb_write_data,
        input  branch_address, branch_taken, stall, flush_if_id,
        input  id_ex_pc_plus4, id_ex_rd1, id_ex_rd2, id_ex_imm,
        input  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_ctrl
    );

    modport slave (
        input  if_id_pc_plus4, if_id_instr, wb_reg_write, wb_write_reg, wb_write_data,
        output branch_address, branch_taken, stall, flush_if_id,
        output id_ex_pc_plus4, id_ex_rd1, id_ex_rd2, id_ex_imm,
        output id_ex_rs, id_ex_rt, id_ex_rd, id_ex_ctrl
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: register file, control decode, early BEQ, load-use hazard, ID/EX register
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears ID/EX and the register file)
//   bus : decode_stage_if.slave (IF/ID inputs, writeback port, branch/hazard outputs, ID/EX outputs)
// id_ex_ctrl layout: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}
module decode_stage #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam int CTRL_MEM_READ = 4;

    logic [DATA_W-1:0] regs [REG_COUNT];

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [8:0]        ctrl;
    logic              uses_rt;
    logic              hazard;
    logic              is_beq;

    assign opcode   = bus.if_id_instr[31:26];
    assign rs       = bus.if_id_instr[25:21];
    assign rt       = bus.if_id_instr[20:16];
    assign rd       = bus.if_id_instr[15:11];
    assign imm_sext = {{(DATA_W-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};

    // Register 0 is hard-wired to zero; a same-cycle writeback to the source is
    // bypassed so the reader never sees the stale value.
    always_comb begin
        rd1 = '0;
        if (rs != 5'd0) begin
            if (bus.wb_reg_write && bus.wb_write_reg == rs)
                rd1 = bus.wb_write_data;
            else
                rd1 = regs[rs];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rt != 5'd0) begin
            if (bus.wb_reg_write && bus.wb_write_reg == rt)
                rd2 = bus.wb_write_data;
            else
                rd2 = regs[rt];
        end
    end

    always_comb begin
        ctrl = 9'b0;
        case (opcode)
            OP_RTYPE: ctrl = 9'b1_0_0_1_0_0_0_10;
            OP_LW:    ctrl = 9'b0_1_1_1_1_0_0_00;
            OP_SW:    ctrl = 9'b0_1_0_0_0_1_0_00;
            OP_BEQ:   ctrl = 9'b0_0_0_0_0_0_1_01;
            OP_ADDI:  ctrl = 9'b0_1_0_1_0_0_0_00;
            default:  ctrl = 9'b0;
        endcase
    end

    // rt is only a source for R-type, SW and BEQ; for LW/ADDI it is the destination.
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign hazard  = bus.id_ex_ctrl[CTRL_MEM_READ] && (bus.id_ex_rt != 5'd0) &&
                     ((bus.id_ex_rt == rs) || ((bus.id_ex_rt == rt) && uses_rt));
    assign is_beq  = (opcode == OP_BEQ);

    assign bus.stall          = hazard;
    assign bus.branch_address = bus.if_id_pc_plus4 + {imm_sext[DATA_W-3:0], 2'b00};
    assign bus.branch_taken   = is_beq && (rd1 == rd2) && !hazard && !rst;
    assign bus.flush_if_id    = bus.branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else if (bus.wb_reg_write && bus.wb_write_reg != 5'd0) begin
            regs[bus.wb_write_reg] <= bus.wb_write_data;
        end
    end

    // Data fields load even during a stall; only the control word becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.id_ex_pc_plus4 <= '0;
            bus.id_ex_rd1      <= '0;
            bus.id_ex_rd2      <= '0;
            bus.id_ex_imm      <= '0;
            bus.id_ex_rs       <= '0;
            bus.id_ex_rt       <= '0;
            bus.id_ex_rd       <= '0;
            bus.id_ex_ctrl     <= '0;
        end else begin
            bus.id_ex_pc_plus4 <= bus.if_id_pc_plus4;
            bus.id_ex_rd1      <= rd1;
            bus.id_ex_rd2      <= rd2;
            bus.id_ex_imm      <= imm_sext;
            bus.id_ex_rs       <= rs;
            bus.id_ex_rt       <= rt;
            bus.id_ex_rd       <= rd;
            bus.id_ex_ctrl     <= hazard ? 9'b0 : ctrl;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - Directed self-checking bench for decode_stage
module tb_decode_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decode_stage_if bus_if ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [8:0] CTRL_R    = 9'h122;
    localparam logic [8:0] CTRL_LW   = 9'h0F0;
    localparam logic [8:0] CTRL_SW   = 9'h088;
    localparam logic [8:0] CTRL_BEQ  = 9'h005;
    localparam logic [8:0] CTRL_ADDI = 9'h0A0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        bus_if.if_id_instr    = instr;
        bus_if.if_id_pc_plus4 = pc4;
        bus_if.wb_reg_write   = we;
        bus_if.wb_write_reg   = wreg;
        bus_if.wb_write_data  = wdata;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc4"},  bus_if.id_ex_pc_plus4, 32'h0);
        check({tag, "_rd1"},  bus_if.id_ex_rd1, 32'h0);
        check({tag, "_rd2"},  bus_if.id_ex_rd2, 32'h0);
        check({tag, "_imm"},  bus_if.id_ex_imm, 32'h0);
        check({tag, "_rs"},   {27'b0, bus_if.id_ex_rs}, 32'h0);
        check({tag, "_rt"},   {27'b0, bus_if.id_ex_rt}, 32'h0);
        check({tag, "_rd"},   {27'b0, bus_if.id_ex_rd}, 32'h0);
        check({tag, "_ctrl"}, {23'b0, bus_if.id_ex_ctrl}, 32'h0);
        check({tag, "_stall"}, {31'b0, bus_if.stall}, 32'h0);
        check({tag, "_bt"},   {31'b0, bus_if.branch_taken}, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset: a beq $0,$0 would be taken, but reset forces branch_taken low.
        rst = 1'b1;
        drive(32'h1000FFFF, 32'h100, 1'b1, 5'd5, 32'h11111111);
        check("rst_bt_gated", {31'b0, bus_if.branch_taken}, 32'h0);
        tick();
        tick();
        check_all_zero("reset");

        // Bypassed WB write of $5 seen by add $3,$5,$0.
        rst = 1'b0;
        drive(32'h00A01820, 32'h4, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("add_rd1_bypass", bus_if.id_ex_rd1, 32'hDEADBEEF);
        check("add_ctrl", {23'b0, bus_if.id_ex_ctrl}, {23'b0, CTRL_R});
        check("add_rs", {27'b0, bus_if.id_ex_rs}, 32'd5);
        check("add_rd", {27'b0, bus_if.id_ex_rd}, 32'd3);
        check("add_pc4", bus_if.id_ex_pc_plus4, 32'h4);
        drive(32'h00A01820, 32'h8, 1'b0, 5'd0, 32'h0);
        tick();
        check("add_rd1_stored", bus_if.id_ex_rd1, 32'hDEADBEEF);

        // Writes to $0 are ignored both through the bypass and the array.
        drive(32'h00001820, 32'hC, 1'b1, 5'd0, 32'h00001234);
        tick();
        check("r0_bypass_rd1", bus_if.id_ex_rd1, 32'h0);
        check("r0_bypass_rd2", bus_if.id_ex_rd2, 32'h0);
        drive(32'h00001820, 32'h10, 1'b0, 5'd0, 32'h0);
        tick();
        check("r0_stored", bus_if.id_ex_rd1, 32'h0);

        // $1 = $2 = 7 via NOP cycles.
        drive(32'h0, 32'h14, 1'b1, 5'd1, 32'd7);
        tick();
        drive(32'h0, 32'h18, 1'b1, 5'd2, 32'd7);
        tick();

        // beq $1,$2,-1 at pc_plus4=0x40.
        drive(32'h1022FFFF, 32'h40, 1'b0, 5'd0, 32'h0);
        check("beq_taken", {31'b0, bus_if.branch_taken}, 32'h1);
        check("beq_flush", {31'b0, bus_if.flush_if_id}, 32'h1);
        check("beq_addr", bus_if.branch_address, 32'h3C);
        // Same-cycle WB of $2=8 flips the compare through the bypass.
        drive(32'h1022FFFF, 32'h40, 1'b1, 5'd2, 32'd8);
        check("beq_bypass_not_taken", {31'b0, bus_if.branch_taken}, 32'h0);
        tick();
        check("beq_ctrl", {23'b0, bus_if.id_ex_ctrl}, {23'b0, CTRL_BEQ});
        check("beq_imm", bus_if.id_ex_imm, 32'hFFFFFFFF);
        drive(32'h1022FFFF, 32'h0, 1'b0, 5'd0, 32'h0);
        check("beq_not_taken", {31'b0, bus_if.branch_taken}, 32'h0);
        check("beq_addr_wrap", bus_if.branch_address, 32'hFFFFFFFC);
        drive(32'h10220010, 32'h40, 1'b0, 5'd0, 32'h0);
        check("beq_addr_fwd", bus_if.branch_address, 32'h80);
        tick();

        // SW decode.
        drive(32'hAC220000, 32'h44, 1'b0, 5'd0, 32'h0);
        tick();
        check("sw_ctrl", {23'b0, bus_if.id_ex_ctrl}, {23'b0, CTRL_SW});

        // lw $2,0($1) then add $4,$2,$2: one-cycle stall, WB during stall visible on retry.
        drive(32'h8C220000, 32'h48, 1'b0, 5'd0, 32'h0);
        tick();
        check("lw_ctrl", {23'b0, bus_if.id_ex_ctrl}, {23'b0, CTRL_LW});
        check("lw_rt", {27'b0, bus_if.id_ex_rt}, 32'd2);
        drive(32'h00422020, 32'h4C, 1'b1, 5'd2, 32'h55);
        check("lu_stall", {31'b0, bus_if.stall}, 32'h1);
        tick();
        check("lu_bubble", {23'b0, bus_if.id_ex_ctrl}, 32'h0);
        drive(32'h00422020, 32'h4C, 1'b0, 5'd0, 32'h0);
        check("lu_stall_done", {31'b0, bus_if.stall}, 32'h0);
        tick();
        check("lu_retry_ctrl", {23'b0, bus_if.id_ex_ctrl}, {23'b0, CTRL_R});
        check("lu_retry_rd1", bus_if.id_ex_rd1, 32'h55);
        check("lu_retry_rd2", bus_if.id_ex_rd2, 32'h55);
        check("lu_retry_rd", {27'b0, bus_if.id_ex_rd}, 32'd4);

        // LW followed by ADDI writing the same rt: no stall.
        drive(32'h8C220000, 32'h50, 1'b0, 5'd0, 32'h0);
        tick();
        drive(32'h20A20001, 32'h54, 1'b0, 5'd0, 32'h0);
        check("addi_no_stall", {31'b0, bus_if.stall}, 32'h0);
        tick();
        check("addi_ctrl", {23'b0, bus_if.id_ex_ctrl}, {23'b0, CTRL_ADDI});
        check("addi_imm", bus_if.id_ex_imm, 32'h1);

        // LW to $0 never stalls.
        drive(32'h8C200000, 32'h58, 1'b0, 5'd0, 32'h0);
        tick();
        drive(32'h00002020, 32'h5C, 1'b0, 5'd0, 32'h0);
        check("lw_r0_no_stall", {31'b0, bus_if.stall}, 32'h0);
        tick();

        // lw $1 then beq $1,$1: stalled branch is not taken.
        drive(32'h8C210000, 32'h60, 1'b0, 5'd0, 32'h0);
        tick();
        drive(32'h1021FFFF, 32'h64, 1'b0, 5'd0, 32'h0);
        check("beq_stall", {31'b0, bus_if.stall}, 32'h1);
        check("beq_stall_bt", {31'b0, bus_if.branch_taken}, 32'h0);
        tick();
        check("beq_retry_bt", {31'b0, bus_if.branch_taken}, 32'h1);
        tick();

        // Unknown opcode 0x3F decodes as NOP.
        drive(32'hFC000000, 32'h68, 1'b0, 5'd0, 32'h0);
        tick();
        check("unk_ctrl", {23'b0, bus_if.id_ex_ctrl}, 32'h0);

        // Reset during a stall (with a pending WB) clears everything.
        drive(32'h8C220000, 32'h6C, 1'b0, 5'd0, 32'h0);
        tick();
        drive(32'h00422020, 32'h70, 1'b1, 5'd7, 32'h77);
        check("pre_rst_stall", {31'b0, bus_if.stall}, 32'h1);
        rst = 1'b1;
        tick();
        check_all_zero("rst_in_stall");
        rst = 1'b0;
        drive(32'h00A73820, 32'h74, 1'b0, 5'd0, 32'h0);
        tick();
        check("post_rst_r5", bus_if.id_ex_rd1, 32'h0);
        check("post_rst_r7", bus_if.id_ex_rd2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
